mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_picker.sv | 33 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  // Port indices are sized for the largest supported port count (8), so one
  // index type serves every NUM_REQ setting.
  localparam int MAX_REQ    = 8;
  localparam int PORT_IDX_W = $clog2(MAX_REQ);

  localparam int PORT_CPU   = 0;
  localparam int PORT_VIDEO = 1;
  localparam int PORT_DMA   = 2;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Next port in round-robin order, wrapping at n.
  function automatic port_idx_t next_port(input port_idx_t p, input int n);
    return (int'(p) == n - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first requesting port at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o=0 when no port requests.
// Ports: req_i request vector, ptr_i start index, gnt_o one-hot pick, found_o pick valid.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  port_idx_t          ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               found_o
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_o && (i == idx) && req_i[i]) begin
          gnt_o[i] = 1'b1;
          found_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between NUM_REQ requesters: lock > starved > CPU priority > round-robin.
// Latency: grant and memory command combinational; read data returns READ_LATENCY cycles after grant.
// Backpressure: a requester holds req until it sees gnt; no stall on the read return path.
// Ports: req/lock/we/addr/wdata per requester in; gnt, rvalid/rdata out;
//        mem_we/mem_addr/mem_in to memory, mem_out from memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int PRIO0        = 1,
  parameter int MAX_WAIT     = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  input  logic [DATA_W-1:0]         mem_out,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_in
);

  localparam int             WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  port_idx_t                rr_q, rr_d;
  port_idx_t                owner_q, owner_d;
  logic                     own_vld_q, own_vld_d;
  logic [WCW-1:0]           wait_q [NUM_REQ];
  logic [WCW-1:0]           wait_d [NUM_REQ];
  logic [READ_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
  port_idx_t                pipe_idx_q [READ_LATENCY];
  port_idx_t                pipe_idx_d [READ_LATENCY];

  port_idx_t                sel_idx;
  logic [NUM_REQ-1:0]       rr_gnt;
  logic                     rr_found;
  logic                     via_rr;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
    .req_i   (req),
    .ptr_i   (rr_q),
    .gnt_o   (rr_gnt),
    .found_o (rr_found)
  );

  // Grant selection, first rule that hits wins. Nothing is granted in reset.
  always_comb begin
    logic hit;
    hit    = 1'b0;
    gnt    = '0;
    via_rr = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (own_vld_q && (owner_q == port_idx_t'(i)) && req[i]) begin
          gnt[i] = 1'b1;
          hit    = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hit && req[i] && (wait_q[i] == WAIT_SAT)) begin
          gnt[i] = 1'b1;
          hit    = 1'b1;
        end
      end
      if (!hit && (PRIO0 != 0) && req[0]) begin
        gnt[0] = 1'b1;
        hit    = 1'b1;
      end
      if (!hit && rr_found) begin
        gnt    = rr_gnt;
        via_rr = 1'b1;
      end
    end
  end

  // Memory command mux for the granted port; all zero when idle.
  always_comb begin
    sel_idx  = '0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_in   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_idx  = port_idx_t'(i);
        mem_we   = we[i];
        mem_addr = addr[i*ADDR_W +: ADDR_W];
        mem_in   = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_d      = via_rr ? next_port(sel_idx, NUM_REQ) : rr_q;
    // Every grant re-decides ownership. With no grant the owner cannot have
    // been requesting (it would have won), so ownership lapses.
    own_vld_d = |(gnt & lock);
    owner_d   = sel_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !gnt[i]) begin
        wait_d[i] = (wait_q[i] == WAIT_SAT) ? wait_q[i] : wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = '0;
      end
    end
    pipe_vld_d[0] = |(gnt & ~we);
    pipe_idx_d[0] = sel_idx;
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_idx_d[s] = pipe_idx_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      owner_q    <= '0;
      own_vld_q  <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
      for (int s = 0; s < READ_LATENCY; s++) pipe_idx_q[s] <= '0;
    end else begin
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      own_vld_q  <= own_vld_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
      for (int s = 0; s < READ_LATENCY; s++) pipe_idx_q[s] <= pipe_idx_d[s];
    end
  end

  // Read return from the pipe tail; suppressed while in reset so in-flight
  // reads are never reported.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!rst && pipe_vld_q[READ_LATENCY-1]) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pipe_idx_q[READ_LATENCY-1] == port_idx_t'(i)) rvalid[i] = 1'b1;
      end
      rdata = mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench: two arbiter instances (pure round-robin RL=1; CPU priority, MAX_WAIT=3, RL=2)
// driven by scripted and random requesters, checked by a queue scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int P0   [2] = '{0, 1};
  localparam int MW   [2] = '{15, 3};
  localparam int RLAT [2] = '{1, 2};

  typedef struct { bit vld; bit we; bit lk; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;
  typedef struct { int k; int g; bit we; logic [AW-1:0] a; logic [DW-1:0] d; } gexp_t;
  typedef struct { int k; int p; logic [DW-1:0] d; int due; } rexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [1:0][N-1:0]        req_s, lock_s, we_s;
  logic [1:0][N*AW-1:0]     addr_s;
  logic [1:0][N*DW-1:0]     wd_s;
  logic [1:0][N-1:0]        gnt_w, rv_w;
  logic [1:0][DW-1:0]       rdata_w, mem_out_w, mem_in_w;
  logic [1:0][AW-1:0]       mem_addr_w;
  logic [1:0]               mem_we_w;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1),
                .PRIO0(0), .MAX_WAIT(15)) dut_rr (
    .clk(clk), .rst(rst), .req(req_s[0]), .lock(lock_s[0]), .we(we_s[0]),
    .addr(addr_s[0]), .wdata(wd_s[0]), .gnt(gnt_w[0]), .rvalid(rv_w[0]),
    .rdata(rdata_w[0]), .mem_out(mem_out_w[0]), .mem_we(mem_we_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_in(mem_in_w[0]));

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2),
                .PRIO0(1), .MAX_WAIT(3)) dut_pr (
    .clk(clk), .rst(rst), .req(req_s[1]), .lock(lock_s[1]), .we(we_s[1]),
    .addr(addr_s[1]), .wdata(wd_s[1]), .gnt(gnt_w[1]), .rvalid(rv_w[1]),
    .rdata(rdata_w[1]), .mem_out(mem_out_w[1]), .mem_we(mem_we_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_in(mem_in_w[1]));

  // Memory: word content is a fixed function of the address (0x1234 -> 0xBEEF),
  // returned after each instance's read latency.
  function automatic logic [DW-1:0] data_fn(input logic [AW-1:0] a);
    return {1'b0, a} ^ 16'hACDB;
  endfunction

  logic [AW-1:0]      h0;
  logic [1:0][AW-1:0] h1;
  always_ff @(posedge clk) begin
    h0    <= mem_addr_w[0];
    h1[0] <= mem_addr_w[1];
    h1[1] <= h1[0];
  end
  assign mem_out_w[0] = data_fn(h0);
  assign mem_out_w[1] = data_fn(h1[1]);

  // Requesters, reference model state, scoreboard.
  txn_t   pend [2][N];
  txn_t   script [2*N][$];
  logic [N-1:0] cont;
  bit     rnd_on;
  int     m_rr [2];
  int     m_own [2];
  int     m_wait [2][N];
  gexp_t  gq [$];
  rexp_t  rq [$];
  int     glog [2][$];
  int     rv_cnt [2][N];
  int     cyc, total, bad;
  bit     running;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // code holds the expected grant sequence one hex digit per grant.
  task automatic chk_seq(input string nm, input int k, input int n, input int code);
    int e, a;
    chk($sformatf("%s_inst%0d_len", nm, k), glog[k].size(), n);
    for (int i = 0; i < n; i++) begin
      e = (code >> (4 * (n - 1 - i))) & 15;
      a = (i < glog[k].size()) ? glog[k][i] : -1;
      chk($sformatf("%s_inst%0d_%0d", nm, k, i), a, e);
    end
  endtask

  function automatic txn_t rnd_txn(input bit allow_w, input bit allow_lk);
    txn_t t;
    t.vld = 1'b1;
    t.we  = allow_w && ($urandom_range(0, 2) == 0);
    t.lk  = allow_lk && ($urandom_range(0, 4) == 0);
    t.a   = AW'($urandom);
    t.d   = DW'($urandom);
    return t;
  endfunction

  // Arbitration rules applied directly to the pending requests of instance k.
  task automatic model(input int k, input bit r, output int g);
    bit via_rr;
    int p;
    via_rr = 0;
    g = -1;
    if (r) begin
      m_rr[k] = 0;
      m_own[k] = -1;
      for (int i = 0; i < N; i++) m_wait[k][i] = 0;
      return;
    end
    if (m_own[k] >= 0 && pend[k][m_own[k]].vld) g = m_own[k];
    for (int i = 0; i < N; i++)
      if (g < 0 && pend[k][i].vld && m_wait[k][i] == MW[k]) g = i;
    if (g < 0 && P0[k] == 1 && pend[k][0].vld) g = 0;
    for (int j = 0; j < N; j++) begin
      p = (m_rr[k] + j) % N;
      if (g < 0 && pend[k][p].vld) begin
        g = p;
        via_rr = 1;
      end
    end
    if (via_rr) m_rr[k] = (g + 1) % N;
    m_own[k] = (g >= 0 && pend[k][g].lk) ? g : -1;
    for (int i = 0; i < N; i++)
      m_wait[k][i] = (pend[k][i].vld && i != g) ? ((m_wait[k][i] < MW[k]) ? m_wait[k][i] + 1 : MW[k]) : 0;
  endtask

  task automatic step(input bit r);
    int g;
    gexp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < N; p++) begin
        if (r) pend[k][p].vld = 0;
        else if (!pend[k][p].vld) begin
          if (script[k*N+p].size() > 0) pend[k][p] = script[k*N+p].pop_front();
          else if (cont[p]) pend[k][p] = rnd_txn(0, 0);
          else if (rnd_on && $urandom_range(0, 99) < 30) pend[k][p] = rnd_txn(1, 1);
        end else if (rnd_on && $urandom_range(0, 99) < 3) pend[k][p].vld = 0;
        req_s[k][p]           = pend[k][p].vld;
        lock_s[k][p]          = pend[k][p].lk;
        we_s[k][p]            = pend[k][p].we;
        addr_s[k][p*AW +: AW] = pend[k][p].a;
        wd_s[k][p*DW +: DW]   = pend[k][p].d;
      end
      if (r) begin
        for (int i = rq.size() - 1; i >= 0; i--)
          if (rq[i].k == k && rq[i].due >= cyc) rq.delete(i);
      end
      model(k, r, g);
      e.k = k; e.g = g; e.we = 0; e.a = '0; e.d = '0;
      if (g >= 0) begin
        e.we = pend[k][g].we;
        e.a  = pend[k][g].a;
        e.d  = pend[k][g].d;
        if (!pend[k][g].we) rq.push_back('{k: k, p: g, d: data_fn(pend[k][g].a), due: cyc + RLAT[k]});
        pend[k][g].vld = 0;
      end
      gq.push_back(e);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      glog[k].delete();
      for (int p = 0; p < N; p++) rv_cnt[k][p] = 0;
    end
  endtask

  // Monitor: compare every cycle's grant/command and read return with the queues.
  initial begin
    gexp_t e;
    logic [N-1:0] exp_v;
    int idx;
    forever begin
      @(negedge clk);
      if (running) begin
        for (int k = 0; k < 2; k++) begin
          if (gq.size() > 0) begin
            e = gq.pop_front();
            exp_v = '0;
            if (e.g >= 0) exp_v[e.g] = 1'b1;
            total++;
            if (gnt_w[e.k] !== exp_v || mem_we_w[e.k] !== e.we ||
                mem_addr_w[e.k] !== e.a || mem_in_w[e.k] !== e.d) begin
              bad++;
              $display("FAIL grant inst%0d cyc%0d: got gnt=%b we=%b addr=%h wd=%h, want gnt=%b we=%b addr=%h wd=%h",
                       e.k, cyc, gnt_w[e.k], mem_we_w[e.k], mem_addr_w[e.k], mem_in_w[e.k],
                       exp_v, e.we, e.a, e.d);
            end
            for (int p = 0; p < N; p++) if (gnt_w[e.k][p]) glog[e.k].push_back(p);
          end
        end
        for (int k = 0; k < 2; k++) begin
          idx = -1;
          for (int i = 0; i < rq.size(); i++) if (idx < 0 && rq[i].k == k) idx = i;
          total++;
          if (idx >= 0 && rq[idx].due == cyc) begin
            exp_v = '0;
            exp_v[rq[idx].p] = 1'b1;
            if (rv_w[k] !== exp_v || rdata_w[k] !== rq[idx].d) begin
              bad++;
              $display("FAIL rdata inst%0d cyc%0d: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                       k, cyc, rv_w[k], rdata_w[k], exp_v, rq[idx].d);
            end
            rq.delete(idx);
          end else if (rv_w[k] !== '0 || rdata_w[k] !== '0) begin
            bad++;
            $display("FAIL rdata_idle inst%0d cyc%0d: got rvalid=%b rdata=%h, want 0 0",
                     k, cyc, rv_w[k], rdata_w[k]);
          end
          for (int p = 0; p < N; p++) if (rv_w[k][p]) rv_cnt[k][p]++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_s = '0; lock_s = '0; we_s = '0; addr_s = '0; wd_s = '0;
    cont = '0; rnd_on = 0; cyc = 0; total = 0; bad = 0;
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1;
      for (int p = 0; p < N; p++) pend[k][p].vld = 0;
    end
    running = 1;

    // Reset then idle.
    step(1); step(1);
    repeat (3) step(0);
    settle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("idle_gnt_inst%0d", k), int'(gnt_w[k]), 0);
      chk($sformatf("idle_mem_we_inst%0d", k), int'(mem_we_w[k]), 0);
      chk($sformatf("idle_mem_addr_inst%0d", k), int'(mem_addr_w[k]), 0);
      chk($sformatf("idle_rvalid_inst%0d", k), int'(rv_w[k]), 0);
    end

    // Single read from the video port.
    clr();
    for (int k = 0; k < 2; k++)
      script[k*N+PORT_VIDEO].push_back('{vld: 1'b1, we: 1'b0, lk: 1'b0, a: 15'h1234, d: 16'h0});
    repeat (4) step(0);
    settle();
    for (int k = 0; k < 2; k++) begin
      chk_seq("single_read", k, 1, 'h1);
      chk($sformatf("single_rvalid_inst%0d", k), rv_cnt[k][PORT_VIDEO], 1);
    end

    // All three ports requesting continuously.
    step(1); step(1);
    clr();
    cont = 3'b111;
    repeat (6) step(0);
    settle();
    chk_seq("rr_order", 0, 6, 'h012012);
    cont = '0;

    // CPU and DMA requesting continuously.
    step(1); step(1);
    clr();
    cont = 3'b101;
    repeat (8) step(0);
    settle();
    chk_seq("prio_starve", 1, 8, 'h00020002);
    chk_seq("rr_two_ports", 0, 8, 'h02020202);
    cont = '0;

    // Locked 4-beat DMA burst while the CPU requests.
    step(1); step(1);
    clr();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        script[k*N+PORT_DMA].push_back('{vld: 1'b1, we: 1'b0, lk: 1'b1, a: AW'(16 + i), d: 16'h0});
    step(0);
    cont = 3'b001;
    repeat (4) step(0);
    settle();
    for (int k = 0; k < 2; k++) chk_seq("lock_burst", k, 5, 'h22220);
    cont = '0;
    repeat (4) step(0);
    settle();
    for (int k = 0; k < 2; k++) chk($sformatf("lock_rvalid_inst%0d", k), rv_cnt[k][PORT_DMA], 4);

    // Reset in the cycle after a read grant drops the read.
    step(1); step(1);
    clr();
    for (int k = 0; k < 2; k++)
      script[k*N+PORT_VIDEO].push_back('{vld: 1'b1, we: 1'b0, lk: 1'b0, a: 15'h0055, d: 16'h0});
    step(0);
    step(1);
    repeat (4) step(0);
    settle();
    for (int k = 0; k < 2; k++) chk($sformatf("rst_drop_inst%0d", k), rv_cnt[k][PORT_VIDEO], 0);
    clr();
    cont = 3'b111;
    repeat (3) step(0);
    settle();
    chk_seq("post_rst_rr", 0, 3, 'h012);
    chk_seq("post_rst_prio", 1, 3, 'h000);
    cont = '0;

    // Random traffic with writes, locks and abandons, then drain.
    step(1); step(1);
    rnd_on = 1;
    repeat (600) step(0);
    rnd_on = 0;
    repeat (40) step(0);
    settle();
    running = 0;
    chk("grant_queue_drained", gq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
